filter_mode_ctrl: RTL and testbench

FILTER_MODE_CTRL -- requirements
Module: filter_mode_ctrl

---
 rtl/filter_mode_ctrl_pkg.sv | 44 ++++
 rtl/filter_mode_ctrl_btn_debounce.sv | 50 +++++
 rtl/filter_mode_ctrl.sv | 138 +++++++++++++
 tb/tb_filter_mode_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/filter_mode_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// filter_mode_ctrl_pkg : shared filter mode codes, FSM states, step helpers
// Rev 1.0
// ============================================================================
package filter_mode_ctrl_pkg;

    localparam logic [2:0] COLOR_INIT  = 3'd0;
    localparam logic [2:0] COLOR_BLACK = 3'd1;
    localparam logic [2:0] COLOR_WHITE = 3'd2;
    localparam logic [2:0] COLOR_RED   = 3'd3;
    localparam logic [2:0] COLOR_GREEN = 3'd4;
    localparam logic [2:0] COLOR_BLUE  = 3'd5;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } mode_state_t;

    // Successors are spelled out per code so the cycle order never depends on numbering.
    function automatic logic [2:0] color_next(input logic [2:0] c);
        case (c)
            COLOR_INIT:  return COLOR_BLACK;
            COLOR_BLACK: return COLOR_WHITE;
            COLOR_WHITE: return COLOR_RED;
            COLOR_RED:   return COLOR_GREEN;
            COLOR_GREEN: return COLOR_BLUE;
            default:     return COLOR_INIT;
        endcase
    endfunction

    function automatic logic [2:0] color_prev(input logic [2:0] c);
        case (c)
            COLOR_BLACK: return COLOR_INIT;
            COLOR_WHITE: return COLOR_BLACK;
            COLOR_RED:   return COLOR_WHITE;
            COLOR_GREEN: return COLOR_RED;
            COLOR_BLUE:  return COLOR_GREEN;
            default:     return COLOR_BLUE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/filter_mode_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// btn_debounce : two-flop synchronizer, level debouncer, rising-edge pulse
// Rev 1.0
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_pulse <= 1'b0;
            // Count consecutive samples that disagree with the accepted level.
            if (r_sync[1] != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_cnt   <= '0;
                    r_level <= r_sync[1];
                    r_pulse <= r_sync[1];
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/filter_mode_ctrl.sv
`default_nettype none
// ============================================================================
// filter_mode_ctrl : button/auto driven filter mode select, frame-aligned apply
// Rev 1.0
// ============================================================================
module filter_mode_ctrl
    import filter_mode_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int AUTO_FRAMES     = 120
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_bypass,
    input  logic       auto_en,
    input  logic       frame_start,
    output logic       process_en,
    output logic [2:0] color_type,
    output logic       mode_pending
);

    localparam logic [7:0] AUTO_LAST = 8'(AUTO_FRAMES - 1);

    logic w_next_pls;
    logic w_prev_pls;
    logic w_byp_pls;
    logic w_any_press;
    logic w_step_fwd;
    logic w_step_bwd;
    logic [2:0] w_pend_type_nxt;
    logic       w_pend_en_nxt;
    logic [2:0] w_app_type_nxt;
    logic       w_app_en_nxt;
    logic       w_differs;

    logic [7:0]  r_frame_cnt;
    logic        r_auto_step;
    mode_state_t r_state;
    logic        r_pending_en;
    logic [2:0]  r_pending_type;
    logic        r_process_en;
    logic [2:0]  r_color_type;
    logic        r_mode_pending;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk(vga_clk), .rst_n(rst_n), .i_btn(btn_next), .o_pulse(w_next_pls)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk(vga_clk), .rst_n(rst_n), .i_btn(btn_prev), .o_pulse(w_prev_pls)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_bypass (
        .clk(vga_clk), .rst_n(rst_n), .i_btn(btn_bypass), .o_pulse(w_byp_pls)
    );

    assign w_any_press = w_next_pls | w_prev_pls | w_byp_pls;

    // Auto-cycle frame counter; the step it issues lands one cycle after frame_start.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= 8'd0;
            r_auto_step <= 1'b0;
        end else begin
            r_auto_step <= 1'b0;
            if (!auto_en || w_any_press) begin
                r_frame_cnt <= 8'd0;
            end else if (frame_start) begin
                if (r_frame_cnt == AUTO_LAST) begin
                    r_frame_cnt <= 8'd0;
                    r_auto_step <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    always_comb begin
        // A user press on either button drops a coincident auto step.
        w_step_fwd = (w_next_pls & ~w_prev_pls)
                   | (r_auto_step & ~w_next_pls & ~w_prev_pls);
        w_step_bwd = w_prev_pls & ~w_next_pls;

        w_pend_type_nxt = r_pending_type;
        if (w_step_fwd) begin
            w_pend_type_nxt = color_next(r_pending_type);
        end else if (w_step_bwd) begin
            w_pend_type_nxt = color_prev(r_pending_type);
        end
        w_pend_en_nxt = r_pending_en ^ w_byp_pls;

        w_app_type_nxt = frame_start ? r_pending_type : r_color_type;
        w_app_en_nxt   = frame_start ? r_pending_en   : r_process_en;

        w_differs = (w_pend_type_nxt != w_app_type_nxt) || (w_pend_en_nxt != w_app_en_nxt);
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_pending_en   <= 1'b0;
            r_pending_type <= COLOR_INIT;
            r_process_en   <= 1'b0;
            r_color_type   <= COLOR_INIT;
            r_mode_pending <= 1'b0;
        end else begin
            r_pending_en   <= w_pend_en_nxt;
            r_pending_type <= w_pend_type_nxt;
            r_process_en   <= w_app_en_nxt;
            r_color_type   <= w_app_type_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_differs) begin
                        r_state        <= ST_PENDING;
                        r_mode_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (!w_differs) begin
                        r_state        <= ST_IDLE;
                        r_mode_pending <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_mode_pending <= 1'b0;
                end
            endcase
        end
    end

    assign process_en   = r_process_en;
    assign color_type   = r_color_type;
    assign mode_pending = r_mode_pending;

endmodule
`default_nettype wire

// File: tb/tb_filter_mode_ctrl.sv
`default_nettype none
// ============================================================================
// tb_filter_mode_ctrl : directed self-checking bench for filter_mode_ctrl
// Rev 1.0
// ============================================================================
module tb_filter_mode_ctrl;
    import filter_mode_ctrl_pkg::*;

    logic       vga_clk     = 1'b0;
    logic       rst_n       = 1'b0;
    logic       btn_next    = 1'b0;
    logic       btn_prev    = 1'b0;
    logic       btn_bypass  = 1'b0;
    logic       auto_en     = 1'b0;
    logic       frame_start = 1'b0;
    logic       process_en;
    logic [2:0] color_type;
    logic       mode_pending;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 vga_clk = ~vga_clk;

    filter_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_FRAMES(3)
    ) dut (
        .vga_clk(vga_clk),
        .rst_n(rst_n),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .btn_bypass(btn_bypass),
        .auto_en(auto_en),
        .frame_start(frame_start),
        .process_en(process_en),
        .color_type(color_type),
        .mode_pending(mode_pending)
    );

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic en, input logic [2:0] ty, input logic mp);
        chk({tag, ".process_en"},   {2'b00, process_en},   {2'b00, en});
        chk({tag, ".color_type"},   color_type,            ty);
        chk({tag, ".mode_pending"}, {2'b00, mode_pending}, {2'b00, mp});
    endtask

    task automatic frame();
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        cyc(4);
    endtask

    // m: bit0 next, bit1 prev, bit2 bypass; hold then release and let it settle.
    task automatic press(input logic [2:0] m, input int hold);
        btn_next   = m[0];
        btn_prev   = m[1];
        btn_bypass = m[2];
        cyc(hold);
        btn_next   = 1'b0;
        btn_prev   = 1'b0;
        btn_bypass = 1'b0;
        cyc(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc(3);
        chk_out("reset", 1'b0, COLOR_INIT, 1'b0);
        rst_n = 1'b1;
        cyc(2);
        for (int f = 0; f < 5; f++) begin
            frame();
            chk_out("idle_frame", 1'b0, COLOR_INIT, 1'b0);
        end

        press(3'b001, 3);
        chk_out("glitch", 1'b0, COLOR_INIT, 1'b0);
        frame();
        chk_out("glitch_frame", 1'b0, COLOR_INIT, 1'b0);

        press(3'b001, 10);
        chk_out("next_pending", 1'b0, COLOR_INIT, 1'b1);
        frame();
        chk_out("next_applied", 1'b0, COLOR_BLACK, 1'b0);

        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        press(3'b010, 10);
        press(3'b010, 10);
        chk_out("prev2_pending", 1'b0, COLOR_INIT, 1'b1);
        frame();
        chk_out("prev2_applied", 1'b0, COLOR_GREEN, 1'b0);

        press(3'b001, 10);
        chk_out("fwd_pending", 1'b0, COLOR_GREEN, 1'b1);
        press(3'b010, 10);
        chk_out("back_to_applied", 1'b0, COLOR_GREEN, 1'b0);

        press(3'b011, 10);
        chk_out("cancel", 1'b0, COLOR_GREEN, 1'b0);
        frame();
        chk_out("cancel_frame", 1'b0, COLOR_GREEN, 1'b0);

        press(3'b100, 10);
        chk_out("bypass_pending", 1'b0, COLOR_GREEN, 1'b1);
        frame();
        chk_out("bypass_applied", 1'b1, COLOR_GREEN, 1'b0);

        press(3'b001, 10);
        frame();
        chk_out("to_blue", 1'b1, COLOR_BLUE, 1'b0);

        auto_en = 1'b1;
        frame();
        frame();
        chk_out("auto_f2", 1'b1, COLOR_BLUE, 1'b0);
        frame();
        chk_out("auto_f3", 1'b1, COLOR_BLUE, 1'b1);
        frame();
        chk_out("auto_f4", 1'b1, COLOR_INIT, 1'b0);

        // Counter sits at 1 here; one more frame, then a press must restart it.
        frame();
        press(3'b100, 10);
        frame();
        chk_out("restart_f1", 1'b0, COLOR_INIT, 1'b0);
        frame();
        chk_out("restart_f2", 1'b0, COLOR_INIT, 1'b0);
        frame();
        chk_out("restart_f3", 1'b0, COLOR_INIT, 1'b1);
        auto_en = 1'b0;
        frame();
        chk_out("restart_f4", 1'b0, COLOR_BLACK, 1'b0);

        press(3'b100, 10);
        frame();
        chk_out("pre_reset", 1'b1, COLOR_BLACK, 1'b0);
        press(3'b001, 10);
        chk_out("pre_reset_pend", 1'b1, COLOR_BLACK, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, COLOR_INIT, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        frame();
        chk_out("post_reset_frame", 1'b0, COLOR_INIT, 1'b0);

        // Debounced pulse reaches the mode logic on the 7th edge after the raise.
        btn_next = 1'b1;
        cyc(6);
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        chk_out("coincident", 1'b0, COLOR_INIT, 1'b1);
        cyc(3);
        btn_next = 1'b0;
        cyc(10);
        frame();
        chk_out("coincident_next", 1'b0, COLOR_BLACK, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
